// File: rtl/alu32_core_if.sv
// Execute-stage ALU bus: operands and op code in, registered result and flags out.
// Issuer drives in_valid/control/operands; the ALU returns out/out_valid/zero/carry.
interface alu32_core_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [6:0]       control;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;
    logic             carry;

    modport master (
        output in_valid, control, input1, input2,
        input  out, out_valid, zero, carry
    );

    modport slave (
        input  in_valid, control, input1, input2,
        output out, out_valid, zero, carry
    );
endinterface

// File: rtl/alu32_core.sv
// 32-bit registered ALU, 16 ops selected by control[3:0]; latency is exactly 1 cycle.
// Backpressure: none. Every in_valid cycle is accepted, and a result is produced on the next cycle.
module alu32_core (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu32_core_if.slave  bus
);
    localparam int WIDTH = 32;

    logic [3:0]       w_sel;
    logic [4:0]       w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_sra;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_unused_ctrl;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_carry;

    assign w_sel         = bus.control[3:0];
    assign w_unused_ctrl = ^bus.control[6:4];
    assign w_shamt       = bus.input2[4:0];

    // Carry and borrow both come from bit WIDTH of a one-bit-wider add/sub.
    assign w_sum  = {1'b0, bus.input1} + {1'b0, bus.input2};
    assign w_diff = {1'b0, bus.input1} - {1'b0, bus.input2};
    assign w_sra  = $signed(bus.input1) >>> w_shamt;
    assign w_slt  = $signed(bus.input1) < $signed(bus.input2);
    assign w_sltu = bus.input1 < bus.input2;

    always_comb begin
        w_result = '0;
        case (w_sel)
            4'd0:    w_result = w_sum[WIDTH-1:0];
            4'd1:    w_result = w_diff[WIDTH-1:0];
            4'd2:    w_result = bus.input1 ^ bus.input2;
            4'd3:    w_result = bus.input1 | bus.input2;
            4'd4:    w_result = bus.input1 & bus.input2;
            4'd5:    w_result = bus.input1 << w_shamt;
            4'd6:    w_result = bus.input1 >> w_shamt;
            4'd7:    w_result = w_sra;
            4'd8:    w_result = {{(WIDTH-1){1'b0}}, w_slt};
            4'd9:    w_result = {{(WIDTH-1){1'b0}}, w_sltu};
            4'd10:   w_result = bus.input2;
            4'd11:   w_result = bus.input1;
            4'd12:   w_result = ~(bus.input1 | bus.input2);
            4'd13:   w_result = ~(bus.input1 & bus.input2);
            4'd14:   w_result = ~(bus.input1 ^ bus.input2);
            default: w_result = '0;
        endcase
    end

    always_comb begin
        w_carry = 1'b0;
        if (w_sel == 4'd0)
            w_carry = w_sum[WIDTH];
        else if (w_sel == 4'd1)
            w_carry = ~w_diff[WIDTH];
    end

    // Result and flags hold across idle cycles; only out_valid drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_out   <= w_result;
                r_zero  <= (w_result == '0);
                r_carry <= w_carry;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
endmodule

// File: tb/tb_alu32_core.sv
// Directed bench for alu32_core: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations on the directed vectors.
module tb_alu32_core;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu32_core_if #(.WIDTH(32)) bus ();

    alu32_core dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {carry, zero, result} from the operation table using plain arithmetic.
    function automatic logic [33:0] model(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        cy;
        longint unsigned s;
        int unsigned sh;
        sh = b % 32;
        cy = 1'b0;
        case (c % 16)
            0: begin
                s  = longint'(a) + longint'(b);
                r  = a + b;
                cy = (s > 64'h0000_0000_FFFF_FFFF);
            end
            1: begin
                r  = a - b;
                cy = (a >= b);
            end
            2:  r = a ^ b;
            3:  r = a | b;
            4:  r = a & b;
            5:  r = a << sh;
            6:  r = a >> sh;
            7:  r = $signed(a) >>> sh;
            8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  r = (a < b) ? 32'd1 : 32'd0;
            10: r = b;
            11: r = a;
            12: r = ~(a | b);
            13: r = ~(a & b);
            14: r = ~(a ^ b);
            default: r = 32'd0;
        endcase
        return {cy, (r == 32'd0), r};
    endfunction

    logic [31:0] exp_out;
    logic        exp_vld, exp_zero, exp_carry;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_out   <= 32'd0;
            exp_vld   <= 1'b0;
            exp_zero  <= 1'b0;
            exp_carry <= 1'b0;
        end else begin
            exp_vld <= bus.in_valid;
            if (bus.in_valid)
                {exp_carry, exp_zero, exp_out} <= model(bus.control, bus.input1, bus.input2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Model-vs-DUT compare on every cycle after reset is first applied.
    logic compare_en;
    initial compare_en = 1'b0;
    always @(negedge clk) begin
        if (compare_en) begin
            check("model out_valid", 32'(bus.out_valid), 32'(exp_vld));
            check("model out",       bus.out,             exp_out);
            check("model zero",      32'(bus.zero),       32'(exp_zero));
            check("model carry",     32'(bus.carry),      32'(exp_carry));
        end
    end

    // Called at a negedge: drive one op, then check literals one cycle later.
    task automatic apply(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_out, input logic e_zero, input logic e_carry);
        bus.in_valid = 1'b1;
        bus.control  = c;
        bus.input1   = a;
        bus.input2   = b;
        @(negedge clk);
        check("vec out_valid", 32'(bus.out_valid), 32'd1);
        check("vec out",       bus.out,            e_out);
        check("vec zero",      32'(bus.zero),      32'(e_zero));
        check("vec carry",     32'(bus.carry),     32'(e_carry));
    endtask

    task automatic idle(input logic [31:0] hold_out);
        bus.in_valid = 1'b0;
        bus.control  = 7'h0F;
        bus.input1   = 32'hDEAD_BEEF;
        bus.input2   = 32'h1234_5678;
        @(negedge clk);
        check("idle out_valid", 32'(bus.out_valid), 32'd0);
        check("idle out hold",  bus.out,            hold_out);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.control  = 7'd0;
        bus.input1   = 32'd0;
        bus.input2   = 32'd0;
        #1 compare_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out",       bus.out,            32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset zero",      32'(bus.zero),      32'd0);
        check("reset carry",     32'(bus.carry),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        apply(7'h00, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
        apply(7'h01, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1);
        apply(7'h02, 32'd8, 32'd4, 32'd12, 1'b0, 1'b0);
        apply(7'h03, 32'd8, 32'd4, 32'd12, 1'b0, 1'b0);
        apply(7'h04, 32'd8, 32'd4, 32'd0, 1'b1, 1'b0);
        apply(7'h04, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000, 1'b0, 1'b0);
        apply(7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1);
        apply(7'h01, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        apply(7'h07, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0, 1'b0);
        apply(7'h06, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b0);
        apply(7'h05, 32'h0000_0003, 32'h24, 32'h0000_0030, 1'b0, 1'b0);
        apply(7'h08, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        apply(7'h09, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
        apply(7'h0A, 32'h1111_2222, 32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 1'b0);
        apply(7'h0B, 32'h1111_2222, 32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0);
        apply(7'h0C, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0, 1'b0);
        apply(7'h0D, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        apply(7'h0E, 32'h0000_00FF, 32'h0000_0F0F, 32'hFFFF_F00F, 1'b0, 1'b0);
        apply(7'h0F, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b0);

        // Handshake: three back-to-back ops, then two idle cycles holding the last result.
        apply(7'h00, 32'd10, 32'd5, 32'd15, 1'b0, 1'b0);
        apply(7'h01, 32'd10, 32'd5, 32'd5,  1'b0, 1'b1);
        apply(7'h02, 32'd10, 32'd5, 32'd15, 1'b0, 1'b0);
        idle(32'd15);
        idle(32'd15);

        // Reserved control bits must not change the result.
        apply(7'h70, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0);
        apply(7'h71, 32'd4, 32'd4, 32'd0, 1'b1, 1'b1);
        apply(7'h70, 32'd4, 32'd5, 32'd9, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with non-zero outputs and a pending op.
        bus.in_valid = 1'b1;
        bus.control  = 7'h00;
        bus.input1   = 32'hFFFF_FFFF;
        bus.input2   = 32'd1;
        #2 rst_n = 1'b0;
        #1;
        check("async rst out",       bus.out,            32'd0);
        check("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check("async rst zero",      32'(bus.zero),      32'd0);
        check("async rst carry",     32'(bus.carry),     32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst out_valid", 32'(bus.out_valid), 32'd0);
        check("post rst out",       bus.out,            32'd0);

        // Mixed random traffic across all ops, checked by the model each cycle.
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.control  = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 3))
                0:       bus.input1 = 32'hFFFF_FFFF;
                1:       bus.input1 = 32'h8000_0000;
                default: bus.input1 = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       bus.input2 = bus.input1;
                1:       bus.input2 = 32'($urandom_range(0, 64));
                default: bus.input2 = $urandom;
            endcase
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
